// File: rtl/nmos_phase_pkg.sv
// Shared types and constants for the two-phase non-overlapping gate-enable generator.
package nmos_phase_pkg;

  // Wide enough for the largest legal PHASE_LEN / GAP_LEN (255).
  localparam int CNT_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    GAP1,
    PH2,
    GAP2
  } state_t;

endpackage

// File: rtl/nmos_phase_cnt.sv
// Loadable 8-bit down-counter with a zero flag; times both phases and dead gaps.
module nmos_phase_cnt
  import nmos_phase_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_val,
  output logic                zero
);

  logic [CNT_BITS-1:0] count;

  // NOTE: asynchronous active-low reset belongs in the sensitivity list; state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_BITS'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nmos_phase_gen.sv
// Two-phase non-overlapping phi1/phi2 generator with free-run and single-step modes.
module nmos_phase_gen
  import nmos_phase_pkg::*;
#(
  parameter int PHASE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 16
) (
  input  logic             main_clk,
  input  logic             main_rst_n,
  input  logic             run,
  input  logic             step,
  output logic             phi1,
  output logic             phi2,
  output logic             phi1_rise,
  output logic             phi2_rise,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt
);

  if (PHASE_LEN < 1 || PHASE_LEN > 255 || GAP_LEN < 0 || GAP_LEN > 255 || CNT_W < 1)
  begin : g_bad_params
    $fatal(1, "nmos_phase_gen: illegal PHASE_LEN/GAP_LEN/CNT_W");
  end

  localparam logic [CNT_BITS-1:0] PH_LOAD  = CNT_BITS'(PHASE_LEN - 1);
  localparam logic [CNT_BITS-1:0] GAP_LOAD = (GAP_LEN == 0) ? '0 : CNT_BITS'(GAP_LEN - 1);
  localparam bit                  NO_GAP   = (GAP_LEN == 0);

  state_t              state;
  state_t              state_nxt;
  logic                load;
  logic [CNT_BITS-1:0] load_val;
  logic                cycle_end;
  logic                zero;

  nmos_phase_cnt u_cnt (
    .clk      (main_clk),
    .rst_n    (main_rst_n),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = PH_LOAD;
    cycle_end = 1'b0;
    case (state)
      IDLE: if (run || step) begin
        state_nxt = PH1;
        load      = 1'b1;
      end
      PH1: if (zero) begin
        load = 1'b1;
        if (NO_GAP) begin
          state_nxt = PH2;
        end else begin
          state_nxt = GAP1;
          load_val  = GAP_LOAD;
        end
      end
      GAP1: if (zero) begin
        state_nxt = PH2;
        load      = 1'b1;
      end
      PH2: if (zero) begin
        if (NO_GAP) begin
          cycle_end = 1'b1;
        end else begin
          state_nxt = GAP2;
          load      = 1'b1;
          load_val  = GAP_LOAD;
        end
      end
      GAP2: if (zero) cycle_end = 1'b1;
      default: state_nxt = IDLE;
    endcase

    // run is re-sampled only at the end of a full cycle, so dropping it never truncates one.
    if (cycle_end) begin
      if (run) begin
        state_nxt = PH1;
        load      = 1'b1;
        load_val  = PH_LOAD;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state     <= IDLE;
      phi1      <= 1'b0;
      phi2      <= 1'b0;
      phi1_rise <= 1'b0;
      phi2_rise <= 1'b0;
      busy      <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      phi1      <= (state_nxt == PH1);
      phi2      <= (state_nxt == PH2);
      phi1_rise <= (state_nxt == PH1) && (state != PH1);
      phi2_rise <= (state_nxt == PH2) && (state != PH2);
      busy      <= (state_nxt != IDLE);
      if (cycle_end) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/nmos_phase_gen.md
# nmos_phase_gen

Two-phase non-overlapping gate-enable generator for the NMOS switch-level library. Runs off the global simulation clock `main_clk` and produces the `phi1`/`phi2` gate signals that drive the `G` inputs of pass-transistor cells. Each pass cell samples its drain on every `main_clk` edge where its gate is high.
- Guaranteed dead time between phases, so no two pass stages on opposite phases are ever transparent in the same `main_clk` cycle.
- Supports free-run and single-step operation.

## Interface
Parameters:
- `PHASE_LEN`, 4: `main_clk` cycles each phase is high; legal range 1..255.
- `GAP_LEN`, 1: dead cycles after each phase; legal range 0..255 (0 means phases are adjacent but never overlap).
- `CNT_W`, 16: width of `cycle_cnt`.

Ports:
- `main_clk`  in  1  global simulation clock; all state changes on its rising edge.
- `main_rst_n`  in  1  reset, asynchronous assert, active-low.
- `run`  in  1  level; when high, cycles repeat continuously.
- `step`  in  1  one-cycle pulse; requests exactly one full phi1/phi2 cycle from IDLE.
- `phi1`  out  1  phase-1 gate enable, registered.
- `phi2`  out  1  phase-2 gate enable, registered.
- `phi1_rise`  out  1  one-cycle pulse in the first cycle `phi1` is high.
- `phi2_rise`  out  1  one-cycle pulse in the first cycle `phi2` is high.
- `busy`  out  1  high whenever the state is not IDLE.
- `cycle_cnt`  out  CNT_W  number of completed full cycles; wraps modulo 2^CNT_W.

## Operation
- State machine with five states: IDLE, PH1, GAP1, PH2, GAP2.
- A down-counter is loaded on entry to each timed state:
  - PH1 and PH2 load PHASE_LEN-1.
  - GAP1 and GAP2 load GAP_LEN-1.
  - A state exits when the counter reaches 0.
- Transitions:
  - IDLE -> PH1 when `run | step`.
  - PH1 -> GAP1, or PH1 -> PH2 if GAP_LEN=0.
  - GAP1 -> PH2.
  - PH2 -> GAP2, or end-of-cycle if GAP_LEN=0.
  - GAP2 -> end-of-cycle.
- End-of-cycle:
  - `cycle_cnt` increments by 1 (from all-ones it wraps to 0).
  - If `run`=1, go to PH1; otherwise go to IDLE.
- Outputs:
  - `phi1` is high exactly in PH1; `phi2` is high exactly in PH2.
  - `phi1 & phi2` is never 1.
- Deasserting `run` mid-cycle does not truncate anything: the current cycle completes, including GAP2, and the block then returns to IDLE.
- `step` while `busy`=1 is ignored. `step` and `run` asserted together behave as `run`.
- Reset values: state IDLE; `phi1`, `phi2`, `phi1_rise`, `phi2_rise`, `busy` = 0; `cycle_cnt` = 0; counter = 0.
- Reset asserted mid-cycle forces all of the above immediately, without waiting for a clock edge. The first cycle after reset release starts only on a new `run`/`step`.
- Elaboration-time check: PHASE_LEN=0 or out-of-range GAP_LEN is a fatal error.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `run`/`step` sampled high in IDLE at edge k -> `phi1`=`busy`=`phi1_rise`=1 after edge k.
- `phi1` stays high for PHASE_LEN cycles, then stays low for GAP_LEN cycles before `phi2` rises.
- Full cycle length = 2*(PHASE_LEN+GAP_LEN) `main_clk` cycles. Consecutive `run` cycles are back-to-back, with no IDLE cycle in between.
- `cycle_cnt` updates on the same edge as the GAP2 -> PH1/IDLE transition. With GAP_LEN=0, it updates on the PH2 exit edge instead.
- `busy` falls on the same edge that enters IDLE.

## Structure
- Package `nmos_phase_pkg` holds:
  - the state enum (IDLE, PH1, GAP1, PH2, GAP2);
  - the counter width constant (8 bits, covering the 255 parameter limit).
- Sub-module `nmos_phase_cnt` is an 8-bit loadable down-counter with a `zero` flag, reused for both phase and gap timing.
- The top level contains the FSM, the output registers and `cycle_cnt`.

## Test plan
1. PHASE_LEN=4, GAP_LEN=1, hold `run`=1 from cycle 0 -> `phi1` high in cycles 0-3, `phi2` high in cycles 5-8, period 10; `cycle_cnt`=3 after 30 cycles.
2. Pulse `step` once -> exactly one `phi1` pulse (4 cycles) and one `phi2` pulse (4 cycles); `busy` high for 10 cycles; `cycle_cnt`=1; then IDLE.
3. Drop `run` during cycle 2 of PH2 -> `phi2` still lasts 4 cycles, GAP2 still lasts 1 cycle, then IDLE; `cycle_cnt` incremented once.
4. GAP_LEN=0, PHASE_LEN=1 with `run`=1 -> `phi1`/`phi2` alternate every cycle, never both high; `phi1_rise`/`phi2_rise` pulse every 2 cycles.
5. Assert `main_rst_n`=0 mid-PH1 -> all outputs 0 immediately, with no clock edge needed; after release with `run`=0, stays IDLE.
6. CNT_W=4, `run`=1 for 16 cycles of the phi1/phi2 sequence -> `cycle_cnt` wraps 15 -> 0; `step` pulses while `busy`=1 have no effect.
